// File: rtl/m_vmem_rect_fill.sv
// Solid-colour rectangle fill engine for the 256x256 RGB565 video memory.
// Commands are queued in a small FIFO, normalised and clipped to the visible area, then written one pixel per clock.
module m_vmem_rect_fill #(
  parameter int unsigned SCREEN_W   = 240,
  parameter int unsigned SCREEN_H   = 240,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_cmd_valid,
  output logic        w_cmd_ready,
  input  logic [7:0]  w_cmd_x0,
  input  logic [7:0]  w_cmd_y0,
  input  logic [7:0]  w_cmd_x1,
  input  logic [7:0]  w_cmd_y1,
  input  logic [15:0] w_cmd_color,
  output logic        w_st_we,
  output logic [15:0] w_st_wadr,
  output logic [15:0] w_st_wdata,
  output logic        w_busy,
  output logic        w_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  X_MAX = 8'(SCREEN_W - 1);
  localparam logic [7:0]  Y_MAX = 8'(SCREEN_H - 1);

  typedef struct packed {
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [7:0]  x1;
    logic [7:0]  y1;
    logic [15:0] color;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;

  state_t      r_state;
  cmd_t        r_cmd;
  logic [7:0]  r_xl;
  logic [7:0]  r_xh;
  logic [7:0]  r_yh;
  logic [7:0]  r_cx;
  logic [7:0]  r_cy;
  logic        r_we;
  logic [15:0] r_wadr;
  logic [15:0] r_wdata;
  logic        r_done;
  logic        r_busy;

  cmd_t             w_cmd;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_xl;
  logic [7:0]       w_xh;
  logic [7:0]       w_yl;
  logic [7:0]       w_yh;
  logic [7:0]       w_xh_clip;
  logic [7:0]       w_yh_clip;
  logic             w_empty;

  assign w_cmd       = '{x0: w_cmd_x0, y0: w_cmd_y0, x1: w_cmd_x1, y1: w_cmd_y1, color: w_cmd_color};
  assign w_push      = w_cmd_valid && r_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Command FIFO storage; contents need no reset, occupancy is tracked by r_count.
  always_ff @(posedge w_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_cmd;
    end
  end

  // FIFO pointers, occupancy and ready (ready reflects the registered count only).
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  // Normalise corners and clip to the visible area.
  assign w_xl      = (r_cmd.x0 < r_cmd.x1) ? r_cmd.x0 : r_cmd.x1;
  assign w_xh      = (r_cmd.x0 < r_cmd.x1) ? r_cmd.x1 : r_cmd.x0;
  assign w_yl      = (r_cmd.y0 < r_cmd.y1) ? r_cmd.y0 : r_cmd.y1;
  assign w_yh      = (r_cmd.y0 < r_cmd.y1) ? r_cmd.y1 : r_cmd.y0;
  assign w_xh_clip = (w_xh > X_MAX) ? X_MAX : w_xh;
  assign w_yh_clip = (w_yh > Y_MAX) ? Y_MAX : w_yh;
  assign w_empty   = ({1'b0, w_xl} >= 9'(SCREEN_W)) || ({1'b0, w_yl} >= 9'(SCREEN_H));

  // Control FSM with registered write-port and status outputs.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_xl    <= '0;
      r_xh    <= '0;
      r_yh    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_we    <= 1'b0;
      r_wadr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= (r_count != '0) || (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cmd   <= r_mem[r_rptr];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_xl    <= w_xl;
          r_xh    <= w_xh_clip;
          r_yh    <= w_yh_clip;
          r_cx    <= w_xl;
          r_cy    <= w_yl;
          r_state <= w_empty ? S_DONE : S_FILL;
        end
        S_FILL: begin
          r_we    <= 1'b1;
          r_wadr  <= {r_cy, r_cx};
          r_wdata <= r_cmd.color;
          if (r_cx == r_xh) begin
            r_cx <= r_xl;
            if (r_cy == r_yh) begin
              r_state <= S_DONE;
            end else begin
              r_cy <= r_cy + 8'd1;
            end
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cmd_ready = r_ready;
  assign w_st_we     = r_we;
  assign w_st_wadr   = r_wadr;
  assign w_st_wdata  = r_wdata;
  assign w_busy      = r_busy;
  assign w_done      = r_done;

endmodule
